// File: rtl/split_bus_driver.sv
// Splits a 32-bit operand pair into 16-bit hi/lo beats for a narrow multiplier and reassembles its 32-bit result.
// Optional result-wait abort is enabled by defining SPLIT_BUS_DRIVER_TIMEOUT_EN.
module split_bus_driver #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_stb,
    output logic        in_ack,
    output logic [15:0] mul_a,
    output logic        mul_a_stb,
    input  logic        mul_a_ack,
    output logic [15:0] mul_b,
    output logic        mul_b_stb,
    input  logic        mul_b_ack,
    input  logic [15:0] mul_z,
    input  logic        mul_z_stb,
    output logic        mul_z_ack,
    output logic [31:0] out_z,
    output logic        out_z_stb,
    input  logic        out_z_ack,
    output logic        timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A_HI = 3'd1,
        A_LO = 3'd2,
        B_HI = 3'd3,
        B_LO = 3'd4,
        Z_HI = 3'd5,
        Z_LO = 3'd6,
        PUT  = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [15:0] zhi_q, zhi_d;
    logic        in_ack_q, in_ack_d;
    logic [15:0] mul_a_q, mul_a_d;
    logic        mul_a_stb_q, mul_a_stb_d;
    logic [15:0] mul_b_q, mul_b_d;
    logic        mul_b_stb_q, mul_b_stb_d;
    logic        mul_z_ack_q, mul_z_ack_d;
    logic [31:0] out_z_q, out_z_d;
    logic        out_z_stb_q, out_z_stb_d;
    logic        timeout_d;

    // A handshake completes on the edge where our registered stb/ack meets the peer's.
    logic in_xfer, a_xfer, b_xfer, z_xfer, out_xfer;
    assign in_xfer  = in_stb & in_ack_q;
    assign a_xfer   = mul_a_stb_q & mul_a_ack;
    assign b_xfer   = mul_b_stb_q & mul_b_ack;
    assign z_xfer   = mul_z_stb & mul_z_ack_q;
    assign out_xfer = out_z_stb_q & out_z_ack;

    logic in_z_wait;
    assign in_z_wait = (state_q == Z_HI) || (state_q == Z_LO);

    logic abort;

`ifdef SPLIT_BUS_DRIVER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;

    // Abort on the edge that would complete the TIMEOUT_CYCLES-th idle wait cycle.
    assign abort = in_z_wait && !z_xfer && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (in_z_wait && !z_xfer && !abort)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register plus all registered outputs and datapath holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            zhi_q       <= '0;
            in_ack_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_a_stb_q <= 1'b0;
            mul_b_q     <= '0;
            mul_b_stb_q <= 1'b0;
            mul_z_ack_q <= 1'b0;
            out_z_q     <= '0;
            out_z_stb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            zhi_q       <= zhi_d;
            in_ack_q    <= in_ack_d;
            mul_a_q     <= mul_a_d;
            mul_a_stb_q <= mul_a_stb_d;
            mul_b_q     <= mul_b_d;
            mul_b_stb_q <= mul_b_stb_d;
            mul_z_ack_q <= mul_z_ack_d;
            out_z_q     <= out_z_d;
            out_z_stb_q <= out_z_stb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_xfer)  state_d = A_HI;
            A_HI: if (a_xfer)   state_d = A_LO;
            A_LO: if (a_xfer)   state_d = B_HI;
            B_HI: if (b_xfer)   state_d = B_LO;
            B_LO: if (b_xfer)   state_d = Z_HI;
            Z_HI: begin
                if (abort)       state_d = PUT;
                else if (z_xfer) state_d = Z_LO;
            end
            Z_LO: if (abort || z_xfer) state_d = PUT;
            PUT:  if (out_xfer) state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        zhi_d       = zhi_q;
        in_ack_d    = in_ack_q;
        mul_a_d     = mul_a_q;
        mul_a_stb_d = mul_a_stb_q;
        mul_b_d     = mul_b_q;
        mul_b_stb_d = mul_b_stb_q;
        mul_z_ack_d = mul_z_ack_q;
        out_z_d     = out_z_q;
        out_z_stb_d = out_z_stb_q;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ack_d = 1'b1;
                if (in_xfer) begin
                    a_d         = in_a;
                    b_d         = in_b;
                    in_ack_d    = 1'b0;
                    mul_a_d     = in_a[31:16];
                    mul_a_stb_d = 1'b1;
                end
            end
            A_HI: if (a_xfer) mul_a_d = a_q[15:0];
            A_LO: begin
                if (a_xfer) begin
                    mul_a_stb_d = 1'b0;
                    mul_b_d     = b_q[31:16];
                    mul_b_stb_d = 1'b1;
                end
            end
            B_HI: if (b_xfer) mul_b_d = b_q[15:0];
            B_LO: begin
                if (b_xfer) begin
                    mul_b_stb_d = 1'b0;
                    mul_z_ack_d = 1'b1;
                end
            end
            Z_HI, Z_LO: begin
                if (abort) begin
                    mul_z_ack_d = 1'b0;
                    out_z_d     = 32'hFFC0_0000;
                    out_z_stb_d = 1'b1;
                    timeout_d   = 1'b1;
                end else if (z_xfer) begin
                    if (state_q == Z_HI) begin
                        zhi_d = mul_z;
                    end else begin
                        mul_z_ack_d = 1'b0;
                        out_z_d     = {zhi_q, mul_z};
                        out_z_stb_d = 1'b1;
                    end
                end
            end
            PUT: begin
                if (out_xfer) begin
                    out_z_stb_d = 1'b0;
                    in_ack_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign in_ack    = in_ack_q;
    assign mul_a     = mul_a_q;
    assign mul_a_stb = mul_a_stb_q;
    assign mul_b     = mul_b_q;
    assign mul_b_stb = mul_b_stb_q;
    assign mul_z_ack = mul_z_ack_q;
    assign out_z     = out_z_q;
    assign out_z_stb = out_z_stb_q;

endmodule

// File: tb/tb_split_bus_driver.sv
// Randomized bench for split_bus_driver: a transaction-level peer model drives every handshake and
// checks beat contents, ordering, data hold, latency, reset and the optional result-wait abort.
module tb_split_bus_driver;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_stb = 1'b0;
    logic        in_ack;
    logic [15:0] mul_a, mul_b;
    logic        mul_a_stb, mul_b_stb;
    logic        mul_a_ack = 1'b0, mul_b_ack = 1'b0;
    logic [15:0] mul_z = '0;
    logic        mul_z_stb = 1'b0;
    logic        mul_z_ack;
    logic [31:0] out_z;
    logic        out_z_stb;
    logic        out_z_ack = 1'b0;
    logic        timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    split_bus_driver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .in_a(in_a), .in_b(in_b), .in_stb(in_stb), .in_ack(in_ack),
        .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
        .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
        .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
        .out_z(out_z), .out_z_stb(out_z_stb), .out_z_ack(out_z_ack),
        .timeout(timeout)
    );

    function automatic logic roll(input int pct);
        return int'($urandom_range(1, 100)) <= pct;
    endfunction

    // One full operation as seen by the upstream source, the multiplier and the downstream sink.
    // Expected beats are simply the operand halves in hi/lo order; expected result is the z word returned.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                          input int pct, input int a_stall, input int put_stall, output int lat);
        logic [15:0] ab[$];
        logic [15:0] bb[$];
        logic [31:0] got = '0;
        int zi = 0, outs = 0, ins = 0, n = 0, t0 = 0, sa = 0, ps = 0;
        int order_err = 0, hold_err = 0;
        bit acc = 0, done = 0, fin = 0;
        logic pa_stb = 0, pb_stb = 0, po_stb = 0, pa_x = 0, pb_x = 0, po_x = 0;
        logic [15:0] pa_d = '0, pb_d = '0;
        logic [31:0] po_d = '0;
        lat = -1;
        while (!fin && n < 600) begin
            @(negedge clk);
            n++;
            if (pa_stb && !pa_x && (mul_a_stb !== 1'b1 || mul_a !== pa_d)) hold_err++;
            if (pb_stb && !pb_x && (mul_b_stb !== 1'b1 || mul_b !== pb_d)) hold_err++;
            if (po_stb && !po_x && (out_z_stb !== 1'b1 || out_z !== po_d)) hold_err++;
            if (mul_b_stb && ab.size() < 2) order_err++;
            if (mul_z_ack && bb.size() < 2) order_err++;
            if (out_z_stb && zi < 2) order_err++;
            if (done && in_ack) begin
                lat = n - t0;
                fin = 1;
                in_stb = 1'b0;
                mul_z_stb = 1'b0;
            end else begin
                if (!acc) begin
                    in_a = a; in_b = b; in_stb = 1'b1;
                    if (in_ack) begin acc = 1; ins++; t0 = n; end
                end else begin
                    in_a = $urandom; in_b = $urandom;
                    in_stb = out_z_stb ? 1'b1 : roll(50);
                    if (in_stb && in_ack) ins++;
                end
                if (mul_a_stb && ab.size() == 0 && sa < a_stall) begin
                    mul_a_ack = 1'b0;
                    sa++;
                    if (mul_a !== a[31:16]) hold_err++;
                end else mul_a_ack = roll(pct);
                pa_stb = mul_a_stb; pa_d = mul_a; pa_x = mul_a_stb && mul_a_ack;
                if (pa_x) ab.push_back(mul_a);
                mul_b_ack = roll(pct);
                pb_stb = mul_b_stb; pb_d = mul_b; pb_x = mul_b_stb && mul_b_ack;
                if (pb_x) bb.push_back(mul_b);
                mul_z_stb = (zi < 2) && roll(pct);
                mul_z = (zi == 0) ? z[31:16] : (zi == 1) ? z[15:0] : 16'($urandom);
                if (mul_z_stb && mul_z_ack) zi++;
                if (out_z_stb && ps < put_stall) begin
                    out_z_ack = 1'b0;
                    ps++;
                end else out_z_ack = roll(pct);
                po_stb = out_z_stb; po_d = out_z; po_x = out_z_stb && out_z_ack;
                if (po_x) begin got = out_z; outs++; done = 1; end
            end
        end
        tests++; if (!fin) begin fails++; $display("FAIL op_budget: finished=%0d required 1", fin); end
        tests++;
        if (ab.size() != 2 || ab[0] !== a[31:16] || ab[1] !== a[15:0]) begin
            fails++; $display("FAIL a_beats: got %p required %h,%h", ab, a[31:16], a[15:0]);
        end
        tests++;
        if (bb.size() != 2 || bb[0] !== b[31:16] || bb[1] !== b[15:0]) begin
            fails++; $display("FAIL b_beats: got %p required %h,%h", bb, b[31:16], b[15:0]);
        end
        tests++;
        if (outs != 1 || got !== z) begin
            fails++; $display("FAIL out_z: got %h (%0d beats) required %h (1 beat)", got, outs, z);
        end
        tests++; if (ins != 1) begin fails++; $display("FAIL in_accepts: got %0d required 1", ins); end
        tests++; if (order_err != 0) begin fails++; $display("FAIL beat_order: got %0d errors required 0", order_err); end
        tests++; if (hold_err != 0) begin fails++; $display("FAIL data_hold: got %0d errors required 0", hold_err); end
        tests++; if (sa != a_stall) begin fails++; $display("FAIL a_stall_cycles: got %0d required %0d", sa, a_stall); end
        tests++; if (ps != put_stall) begin fails++; $display("FAIL put_stall_cycles: got %0d required %0d", ps, put_stall); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({in_ack, mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack, out_z, out_z_stb, timeout} !== 70'b0) begin
            fails++; $display("FAIL reset_outputs: some output nonzero, in_ack=%b out_z=%h", in_ack, out_z);
        end
        rst = 1'b0;
        #1;
        tests++; if (in_ack !== 1'b0) begin fails++; $display("FAIL in_ack_before_edge: got %b required 0", in_ack); end
        @(negedge clk);
        tests++; if (in_ack !== 1'b1) begin fails++; $display("FAIL in_ack_after_edge: got %b required 1", in_ack); end
    endtask

    task automatic test_basic();
        int lat;
        run_op(32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 100, 0, 0, lat);
        tests++; if (lat != 8) begin fails++; $display("FAIL basic_latency: got %0d required 8", lat); end
    endtask

    task automatic test_stall_a();
        int lat;
        run_op(32'h4040_0000, 32'h4000_0000, $urandom, 100, 5, 0, lat);
        tests++; if (lat != 13) begin fails++; $display("FAIL stall_a_latency: got %0d required 13", lat); end
    endtask

    task automatic test_put_stall();
        int lat;
        run_op($urandom, $urandom, $urandom, 100, 0, 10, lat);
        tests++; if (lat != 18) begin fails++; $display("FAIL put_stall_latency: got %0d required 18", lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom, $urandom, 100, 0, 0, lat);
            tests++; if (lat != 8) begin fails++; $display("FAIL b2b_latency: op %0d got %0d required 8", i, lat); end
        end
    endtask

    task automatic test_random();
        int lat;
        for (int i = 0; i < 40; i++)
            run_op($urandom, $urandom, $urandom, int'($urandom_range(20, 100)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), lat);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int lat;
        mul_a_ack = 1'b1; mul_b_ack = 1'b1; mul_z_stb = 1'b0; out_z_ack = 1'b1;
        @(negedge clk);
        in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_stb = 1'b1;
        @(negedge clk);
        in_stb = 1'b0;
        while (!mul_b_stb && n < 20) begin @(negedge clk); n++; end
        tests++; if (!mul_b_stb) begin fails++; $display("FAIL reach_b_hi: mul_b_stb=%b required 1", mul_b_stb); end
        tests++; if (mul_b !== 16'h9ABC) begin fails++; $display("FAIL b_hi_beat: got %h required 9abc", mul_b); end
        rst = 1'b1;
        #1;
        tests++;
        if ({in_ack, mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack, out_z, out_z_stb, timeout} !== 70'b0) begin
            fails++; $display("FAIL async_reset: mul_b=%h mul_b_stb=%b in_ack=%b", mul_b, mul_b_stb, in_ack);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (in_ack !== 1'b0) begin fails++; $display("FAIL mid_in_ack_early: got %b required 0", in_ack); end
        @(negedge clk);
        tests++;
        if (in_ack !== 1'b1 || out_z_stb !== 1'b0) begin
            fails++; $display("FAIL mid_recover: in_ack=%b out_z_stb=%b required 1,0", in_ack, out_z_stb);
        end
        run_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 100, 0, 0, lat);
        tests++; if (lat != 8) begin fails++; $display("FAIL post_reset_latency: got %0d required 8", lat); end
    endtask

`ifdef SPLIT_BUS_DRIVER_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0, zc = 0;
        mul_a_ack = 1'b1; mul_b_ack = 1'b1; mul_z_stb = 1'b0; out_z_ack = 1'b1;
        @(negedge clk);
        in_a = $urandom; in_b = $urandom; in_stb = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            in_stb = 1'b0;
            if (mul_z_ack) zc++;
            if (timeout) break;
        end
        tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL timeout_pulse: got %b required 1", timeout); end
        tests++; if (zc != TO) begin fails++; $display("FAIL timeout_wait: got %0d cycles required %0d", zc, TO); end
        tests++;
        if (out_z !== 32'hFFC0_0000 || out_z_stb !== 1'b1 || mul_z_ack !== 1'b0) begin
            fails++; $display("FAIL timeout_result: out_z=%h stb=%b zack=%b required ffc00000,1,0", out_z, out_z_stb, mul_z_ack);
        end
        @(negedge clk);
        tests++;
        if (timeout !== 1'b0 || in_ack !== 1'b1 || out_z_stb !== 1'b0) begin
            fails++; $display("FAIL timeout_after: timeout=%b in_ack=%b stb=%b required 0,1,0", timeout, in_ack, out_z_stb);
        end
    endtask
`else
    task automatic test_no_timeout();
        int n = 0, bad = 0;
        mul_a_ack = 1'b1; mul_b_ack = 1'b1; mul_z_stb = 1'b0; out_z_ack = 1'b1;
        @(negedge clk);
        in_a = $urandom; in_b = $urandom; in_stb = 1'b1;
        while (!mul_z_ack && n < 20) begin @(negedge clk); n++; in_stb = 1'b0; end
        tests++; if (mul_z_ack !== 1'b1) begin fails++; $display("FAIL reach_z_hi: mul_z_ack=%b required 1", mul_z_ack); end
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (mul_z_ack !== 1'b1 || timeout !== 1'b0 || out_z_stb !== 1'b0) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL wait_forever: got %0d bad cycles required 0", bad); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (in_ack !== 1'b1) begin fails++; $display("FAIL no_timeout_recover: in_ack=%b required 1", in_ack); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall_a();
        test_put_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef SPLIT_BUS_DRIVER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_basic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
